column_scroller: RTL and testbench



---
 rtl/screen_pkg.sv | 24 ++
 rtl/column_scroller_if.sv | 10 +
 rtl/column_fifo.sv | 52 +++++
 rtl/column_scroller.sv | 75 +++++++
 tb/tb_column_scroller.sv | 314 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/screen_pkg.sv
// Shared geometry for the 16x8 LED frame and helpers for row slicing and column shifting.
package screen_pkg;
   localparam int SCREEN_ROWS = 8;
   localparam int SCREEN_COLS = 16;
   localparam int FRAME_W     = 128;

   function automatic int row_msb(input int r);
      return FRAME_W - 1 - SCREEN_COLS * r;
   endfunction

   function automatic logic [SCREEN_COLS-1:0] row_word(input logic [FRAME_W-1:0] f, input int r);
      return f[row_msb(r) -: SCREEN_COLS];
   endfunction

   // Shift every row left by one pixel; bit r of c lands in row r's rightmost pixel.
   function automatic logic [FRAME_W-1:0] shift_in(input logic [FRAME_W-1:0] f,
                                                   input logic [SCREEN_ROWS-1:0] c);
      logic [FRAME_W-1:0] nxt;
      nxt = '0;
      for (int r = 0; r < SCREEN_ROWS; r++)
         nxt[row_msb(r) -: SCREEN_COLS] = {f[row_msb(r) - 1 -: SCREEN_COLS - 1], c[r]};
      return nxt;
   endfunction
endpackage

// File: rtl/column_scroller_if.sv
// Column stream handshake between a column source and the scroller.
interface column_scroller_if;
   import screen_pkg::*;
   logic [SCREEN_ROWS-1:0] col_data;
   logic                   col_valid;
   logic                   col_ready;

   modport master (output col_data, output col_valid, input col_ready);
   modport slave  (input col_data, input col_valid, output col_ready);
endinterface

// File: rtl/column_fifo.sv
// Small synchronous FIFO; the head is always read from stored state, never bypassed from wdata.
module column_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     clear,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         wdata,
   output logic [WIDTH-1:0]         head,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     full,
   output logic                     empty
);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (level == LW'(DEPTH));
   assign empty   = (level == '0);
   assign do_push = push && !full && !clear;
   assign do_pop  = pop && !empty && !clear;
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         if (do_push && !do_pop)      level <= level + LW'(1);
         else if (do_pop && !do_push) level <= level - LW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end
endmodule

// File: rtl/column_scroller.sv
// Marquee feeder: buffers incoming columns and shifts one into the right edge of the frame
// every STEP_DIV enabled cycles.
module column_scroller
   import screen_pkg::*;
#(
   parameter int STEP_DIV       = 2500000,
   parameter int FIFO_DEPTH     = 4,
   parameter int BLANK_ON_EMPTY = 1
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        enable,
   input  logic                        clear,
   column_scroller_if.slave            col,
   output logic [FRAME_W-1:0]          frame,
   output logic                        step_done,
   output logic [$clog2(FIFO_DEPTH):0] fifo_level
);
   localparam int CW = $clog2(STEP_DIV);

   logic [CW-1:0]          count;
   logic                   step;
   logic                   push;
   logic                   pop;
   logic                   full;
   logic                   empty;
   logic [SCREEN_ROWS-1:0] head;

   assign step          = enable && (count == CW'(STEP_DIV - 1));
   assign col.col_ready = !full && !clear;
   assign push          = col.col_valid && col.col_ready;
   assign pop           = step && !empty;

   column_fifo #(
      .WIDTH (SCREEN_ROWS),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (clear),
      .push  (push),
      .pop   (pop),
      .wdata (col.col_data),
      .head  (head),
      .level (fifo_level),
      .full  (full),
      .empty (empty)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                          count <= '0;
      else if (clear)                      count <= '0;
      else if (step)                       count <= '0;
      else if (enable)                     count <= count + CW'(1);
   end

   // Head comes from stored FIFO state, so a column pushed on a step edge waits for the next step.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frame     <= '0;
         step_done <= 1'b0;
      end else if (clear) begin
         frame     <= '0;
         step_done <= 1'b0;
      end else if (step && !empty) begin
         frame     <= shift_in(frame, head);
         step_done <= 1'b1;
      end else if (step && (BLANK_ON_EMPTY != 0)) begin
         frame     <= shift_in(frame, '0);
         step_done <= 1'b1;
      end else begin
         step_done <= 1'b0;
      end
   end
endmodule

// File: tb/tb_column_scroller.sv
// Bench for column_scroller: two instances (blank-on-empty and hold-on-empty) driven with the
// same stimulus and compared against a column-list reference model.
module tb_column_scroller;
   import screen_pkg::*;

   localparam int STEP_DIV = 4;
   localparam int DEPTH    = 4;
   localparam int LW       = $clog2(DEPTH) + 1;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          enable = 1'b0;
   logic          clear = 1'b0;
   logic [7:0]    col_data = 8'h00;
   logic          col_valid = 1'b0;
   logic [127:0]  frame_a, frame_b;
   logic          sd_a, sd_b;
   logic [LW-1:0] lvl_a, lvl_b;

   column_scroller_if if_a ();
   column_scroller_if if_b ();
   assign if_a.col_data  = col_data;
   assign if_a.col_valid = col_valid;
   assign if_b.col_data  = col_data;
   assign if_b.col_valid = col_valid;

   column_scroller #(.STEP_DIV(STEP_DIV), .FIFO_DEPTH(DEPTH), .BLANK_ON_EMPTY(1)) dut_a (
      .clk(clk), .rst_n(rst_n), .enable(enable), .clear(clear), .col(if_a.slave),
      .frame(frame_a), .step_done(sd_a), .fifo_level(lvl_a));

   column_scroller #(.STEP_DIV(STEP_DIV), .FIFO_DEPTH(DEPTH), .BLANK_ON_EMPTY(0)) dut_b (
      .clk(clk), .rst_n(rst_n), .enable(enable), .clear(clear), .col(if_b.slave),
      .frame(frame_b), .step_done(sd_b), .fifo_level(lvl_b));

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;

   // Reference model: the frame as a list of 16 columns, left to right, plus a column queue.
   int         pcount;
   logic [7:0] q[$];
   logic [7:0] cols_a[16];
   logic [7:0] cols_b[16];
   logic       msd_a, msd_b;
   int         pops, pushes;

   function automatic logic [127:0] build(input logic [7:0] c[16]);
      logic [127:0] f;
      f = '0;
      for (int k = 0; k < 16; k++)
         for (int r = 0; r < 8; r++)
            f[127 - 16 * r - k] = c[k][r];
      return f;
   endfunction

   task automatic model_reset();
      pcount = 0;
      q.delete();
      for (int k = 0; k < 16; k++) begin
         cols_a[k] = 8'h00;
         cols_b[k] = 8'h00;
      end
      msd_a = 1'b0;
      msd_b = 1'b0;
   endtask

   task automatic scroll_a(input logic [7:0] c);
      for (int k = 0; k < 15; k++) cols_a[k] = cols_a[k + 1];
      cols_a[15] = c;
   endtask

   task automatic scroll_b(input logic [7:0] c);
      for (int k = 0; k < 15; k++) cols_b[k] = cols_b[k + 1];
      cols_b[15] = c;
   endtask

   task automatic model_clock();
      logic       ready, step, push;
      logic [7:0] c;
      ready = (q.size() < DEPTH) && !clear;
      if (clear) begin
         model_reset();
      end else begin
         step  = enable && (pcount == STEP_DIV - 1);
         push  = col_valid && ready;
         msd_a = 1'b0;
         msd_b = 1'b0;
         if (step) begin
            if (q.size() > 0) begin
               c = q.pop_front();
               scroll_a(c);
               scroll_b(c);
               msd_a = 1'b1;
               msd_b = 1'b1;
               pops++;
            end else begin
               scroll_a(8'h00);
               msd_a = 1'b1;
            end
         end
         if (push) begin
            q.push_back(col_data);
            pushes++;
         end
         if (enable) pcount = (pcount + 1) % STEP_DIV;
      end
   endtask

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic compare_all();
      logic rdy;
      rdy = (q.size() < DEPTH) && !clear;
      check("frame_a", frame_a, build(cols_a));
      check("frame_b", frame_b, build(cols_b));
      check("step_done_a", 128'(sd_a), 128'(msd_a));
      check("step_done_b", 128'(sd_b), 128'(msd_b));
      check("level_a", 128'(lvl_a), 128'(q.size()));
      check("level_b", 128'(lvl_b), 128'(q.size()));
      check("ready_a", 128'(if_a.col_ready), 128'(rdy));
      check("ready_b", 128'(if_b.col_ready), 128'(rdy));
   endtask

   task automatic tick();
      model_clock();
      @(posedge clk);
      #1;
      compare_all();
   endtask

   typedef struct {
      logic       en;
      logic       vld;
      logic [7:0] data;
      logic       clr;
      int         lvl;
      logic       rdy;
      logic       sd;
      logic [15:0] row0;
   } vec_t;

   vec_t tbl[10];

   initial begin
      #500000;
      $display("FAIL watchdog total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [127:0] saved;
      int n, p0, s0;

      tbl[0] = '{1'b1, 1'b1, 8'h01, 1'b0, 1, 1'b1, 1'b0, 16'h0000};
      tbl[1] = '{1'b1, 1'b0, 8'h00, 1'b0, 1, 1'b1, 1'b0, 16'h0000};
      tbl[2] = '{1'b1, 1'b0, 8'h00, 1'b0, 1, 1'b1, 1'b0, 16'h0000};
      tbl[3] = '{1'b1, 1'b0, 8'h00, 1'b0, 0, 1'b1, 1'b1, 16'h0001};
      tbl[4] = '{1'b0, 1'b1, 8'h80, 1'b0, 1, 1'b1, 1'b0, 16'h0001};
      tbl[5] = '{1'b0, 1'b1, 8'h40, 1'b0, 2, 1'b1, 1'b0, 16'h0001};
      tbl[6] = '{1'b0, 1'b1, 8'h20, 1'b0, 3, 1'b1, 1'b0, 16'h0001};
      tbl[7] = '{1'b0, 1'b1, 8'h10, 1'b0, 4, 1'b0, 1'b0, 16'h0001};
      tbl[8] = '{1'b0, 1'b1, 8'h08, 1'b0, 4, 1'b0, 1'b0, 16'h0001};
      tbl[9] = '{1'b0, 1'b1, 8'h04, 1'b1, 0, 1'b0, 1'b0, 16'h0000};

      pops = 0;
      pushes = 0;
      model_reset();

      // Reset held with a column offered
      col_valid = 1'b1;
      col_data  = 8'h5A;
      repeat (5) begin
         @(posedge clk);
         #1;
         compare_all();
      end
      col_valid = 1'b0;
      rst_n = 1'b1;

      // Table: first step, FIFO fill with enable low, clear
      for (int i = 0; i < 10; i++) begin
         enable    = tbl[i].en;
         col_valid = tbl[i].vld;
         col_data  = tbl[i].data;
         clear     = tbl[i].clr;
         tick();
         check("tbl_level", 128'(lvl_a), 128'(tbl[i].lvl));
         check("tbl_ready", 128'(if_a.col_ready), 128'(tbl[i].rdy));
         check("tbl_step_done", 128'(sd_a), 128'(tbl[i].sd));
         check("tbl_row0", 128'(row_word(frame_a, 0)), 128'(tbl[i].row0));
         if (i == 3) check("first_step_frame", frame_a, 128'h1 << 112);
      end
      clear = 1'b0;
      col_valid = 1'b0;

      // Sixteen all-ones columns, then one blank step
      enable = 1'b1;
      col_data = 8'hFF;
      col_valid = 1'b1;
      p0 = pushes;
      s0 = pops;
      n = 0;
      while (n < 400 && pops - s0 < 16) begin
         if (pushes - p0 >= 16) col_valid = 1'b0;
         tick();
         n++;
      end
      col_valid = 1'b0;
      check("fill_16_pops", 128'(pops - s0), 128'd16);
      check("all_ones_a", frame_a, {128{1'b1}});
      check("all_ones_b", frame_b, {128{1'b1}});
      n = 0;
      do begin
         tick();
         n++;
      end while (!msd_a && n < 20);
      check("blank_step_a", frame_a, {8{16'hFFFE}});
      check("hold_b", frame_b, {128{1'b1}});
      check("hold_b_no_pulse", 128'(sd_b), 128'd0);

      // Full FIFO back-pressure released by the first pop
      enable = 1'b0;
      for (int i = 0; i < 4; i++) begin
         col_data = 8'hA1 + 8'(i);
         col_valid = 1'b1;
         tick();
      end
      check("full_level", 128'(lvl_a), 128'd4);
      check("full_ready", 128'(if_a.col_ready), 128'd0);
      col_data = 8'hA5;
      repeat (2) tick();
      check("held_level", 128'(lvl_a), 128'd4);
      enable = 1'b1;
      n = 0;
      do begin
         tick();
         n++;
      end while (!msd_a && n < 20);
      check("pop_level", 128'(lvl_a), 128'd3);
      check("pop_ready", 128'(if_a.col_ready), 128'd1);
      tick();
      check("refill_level", 128'(lvl_a), 128'd4);
      check("refill_ready", 128'(if_a.col_ready), 128'd0);
      col_valid = 1'b0;

      // Drain, then three empty steps: hold instance must not move
      n = 0;
      while (q.size() > 0 && n < 100) begin
         tick();
         n++;
      end
      check("drain_level", 128'(lvl_b), 128'd0);
      saved = build(cols_b);
      for (int i = 0; i < 3 * STEP_DIV; i++) begin
         tick();
         check("empty_hold_frame", frame_b, saved);
         check("empty_hold_pulse", 128'(sd_b), 128'd0);
      end

      // Clear mid-scroll with two columns buffered
      enable = 1'b0;
      col_data = 8'h3C;
      col_valid = 1'b1;
      tick();
      col_data = 8'hC3;
      tick();
      col_valid = 1'b0;
      check("pre_clear_level", 128'(lvl_a), 128'd2);
      enable = 1'b1;
      tick();
      clear = 1'b1;
      tick();
      clear = 1'b0;
      check("clear_frame_a", frame_a, 128'd0);
      check("clear_frame_b", frame_b, 128'd0);
      check("clear_level", 128'(lvl_a), 128'd0);
      n = 0;
      do begin
         tick();
         n++;
      end while (!sd_a && n < 20);
      check("clear_restart_cycles", 128'(n), 128'(STEP_DIV));

      // Random traffic with one asynchronous reset in the middle
      for (int i = 0; i < 600; i++) begin
         enable    = ($urandom_range(0, 3) != 0);
         clear     = ($urandom_range(0, 40) == 0);
         col_valid = $urandom_range(0, 1) != 0;
         col_data  = 8'($urandom);
         if (i == 300) begin
            @(negedge clk);
            rst_n = 1'b0;
            #1;
            model_reset();
            compare_all();
            @(posedge clk);
            #1;
            compare_all();
            rst_n = 1'b1;
         end
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
